// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the uart frame parser and its future transmit peer.
// Holds the parser state encoding, frame field widths and checksum helper.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int         BYTE_W       = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [BYTE_W-1:0] chk_add(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload buffer: one write port from the parser, one registered read port
// for the host.
module uart_frame_rx_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Pops bytes from the uart RX FIFO and assembles SYNC/LEN/payload/CHK frames,
// holding one good payload for the host until it is acknowledged.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx_ready,
    input  logic [7:0]                 uart_rx_byte,
    output logic                       uart_rx_read,
    output logic                       frame_valid,
    output logic [7:0]                 frame_len,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data,
    input  logic                       frame_ack,
    output logic                       err_chk,
    output logic                       err_len,
    output logic                       err_timeout,
    output logic                       busy
);

    localparam int             AW      = $clog2(MAX_LEN);
    localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]     MAX_L   = 9'(MAX_LEN);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        state, nxt;
    logic          rd_q, pop, active, last;
    logic          e_chk, e_len, e_to;
    logic [7:0]    chk, len;
    logic [AW-1:0] idx;
    logic [TW-1:0] tcnt;

    // rd_q spaces pops so the uart has a cycle to refresh ready
    assign pop          = !rst && uart_rx_ready && (state != ST_HOLD) && !rd_q;
    assign uart_rx_read = pop;
    assign active       = state inside {ST_LEN, ST_PAYLOAD, ST_CHK};
    assign busy         = active;
    assign frame_valid  = (state == ST_HOLD);
    assign last         = (8'(idx) == len - 8'd1);

    always_comb begin
        nxt   = state;
        e_chk = 1'b0;
        e_len = 1'b0;
        e_to  = 1'b0;
        if (pop) begin
            unique case (state)
                ST_HUNT: begin
                    if (uart_rx_byte == SYNC_BYTE) nxt = ST_LEN;
                end
                ST_LEN: begin
                    if ({1'b0, uart_rx_byte} > MAX_L) begin
                        e_len = 1'b1;
                        nxt   = ST_HUNT;
                    end else if (uart_rx_byte == 8'h00) begin
                        nxt = ST_CHK;
                    end else begin
                        nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (last) nxt = ST_CHK;
                end
                ST_CHK: begin
                    if (uart_rx_byte == chk) begin
                        nxt = ST_HOLD;
                    end else begin
                        e_chk = 1'b1;
                        nxt   = ST_HUNT;
                    end
                end
                default: ;
            endcase
        end else if (active && tcnt == TO_LAST) begin
            e_to = 1'b1;
            nxt  = ST_HUNT;
        end
        if (state == ST_HOLD && frame_ack) nxt = ST_HUNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            rd_q        <= 1'b0;
            chk         <= 8'h00;
            len         <= 8'h00;
            idx         <= '0;
            tcnt        <= '0;
            frame_len   <= 8'h00;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= nxt;
            rd_q        <= pop;
            err_chk     <= e_chk;
            err_len     <= e_len;
            err_timeout <= e_to;
            if (pop || !active) tcnt <= '0;
            else                tcnt <= tcnt + TW'(1);
            if (pop && state == ST_LEN) begin
                chk <= uart_rx_byte;
                len <= uart_rx_byte;
                idx <= '0;
            end
            if (pop && state == ST_PAYLOAD) begin
                chk <= chk_add(chk, uart_rx_byte);
                idx <= idx + AW'(1);
            end
            if (state == ST_CHK && nxt == ST_HOLD) frame_len <= len;
        end
    end

    uart_frame_rx_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (pop && state == ST_PAYLOAD),
        .waddr (idx),
        .wdata (uart_rx_byte),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: byte-FIFO model, directed vectors and a random
// byte stream compared against a frame-level reference parser.
module tb_uart_frame_rx;

    localparam int MAX_LEN = 64;
    localparam int TO      = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx_ready = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       uart_rx_read;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       err_chk, err_len, err_timeout, busy;

    uart_frame_rx #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_byte  (uart_rx_byte),
        .uart_rx_read  (uart_rx_read),
        .frame_valid   (frame_valid),
        .frame_len     (frame_len),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_ack     (frame_ack),
        .err_chk       (err_chk),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // uart FIFO model: stream is appended by the test, rp advanced on pops
    logic [7:0] stream[$];
    int rp = 0;

    always @(negedge clk) begin
        uart_rx_ready = (rp < stream.size());
        uart_rx_byte  = (rp < stream.size()) ? stream[rp] : 8'h00;
    end

    always @(posedge clk) begin
        if (uart_rx_read) rp <= rp + 1;
    end

    int n_chk = 0, n_len = 0, n_to = 0, n_excl = 0, n_holdpop = 0;

    always @(negedge clk) begin
        if (err_chk) n_chk++;
        if (err_len) n_len++;
        if (err_timeout) n_to++;
        if (int'(err_chk) + int'(err_len) + int'(err_timeout) > 1) n_excl++;
        if (frame_valid && uart_rx_read) n_holdpop++;
    end

    int checks = 0, errors = 0;

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic quiesce(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rp == stream.size() && !busy) && k < bound);
        if (k >= bound) check("quiesce_bound", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (rp != stream.size() && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) check("drain_bound", 1, 0);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int bound);
        int k = 0;
        while (!frame_valid && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (k >= bound) check("valid_bound", 1, 0);
    endtask

    task automatic read_byte(input int a, output logic [7:0] d);
        @(negedge clk);
        rd_addr = 6'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic do_ack(input string nm);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check(nm, int'(frame_valid), 0);
    endtask

    // Reference: walk the byte stream by frame rules using plain indexing
    logic [7:0] exp_data[$];
    int         exp_len[$];

    function automatic void model(input logic [7:0] s[$],
                                  output int ec, output int el, output int et);
        int i = 0;
        int n = s.size();
        int ln, sum;
        ec = 0; el = 0; et = 0;
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) begin
                et++;
                break;
            end
            ln = int'(s[i+1]);
            if (ln > MAX_LEN) begin
                el++;
                i += 2;
                continue;
            end
            if (i + 2 + ln >= n) begin
                et++;
                break;
            end
            sum = ln;
            for (int k = 0; k < ln; k++) sum += int'(s[i+2+k]);
            if (int'(s[i+2+ln]) == sum % 256) begin
                exp_len.push_back(ln);
                for (int k = 0; k < ln; k++) exp_data.push_back(s[i+2+k]);
            end else begin
                ec++;
            end
            i += 3 + ln;
        end
    endfunction

    typedef struct {
        int          n;
        logic [95:0] bytes;
        logic        valid;
        int          len;
        logic [23:0] data;
        int          e_chk;
        int          e_len;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [7:0] s[$];
        int b_chk, b_len, b_to, b_hp, ec, el, et, sum, ln, r, bad;

        vecs[0] = '{6, 96'hA50311223369, 1'b1, 3, 24'h112233, 0, 0};
        vecs[1] = '{5, 96'h00FFA50000,   1'b1, 0, 24'h000000, 0, 0};
        vecs[2] = '{5, 96'hA502102000,   1'b0, 0, 24'h000000, 1, 0};
        vecs[3] = '{6, 96'hA541A5015A5B, 1'b1, 1, 24'h5A0000, 0, 1};
        vecs[4] = '{5, 96'hA502102032,   1'b1, 2, 24'h102000, 0, 0};
        vecs[5] = '{5, 96'hA502A5A54C,   1'b1, 2, 24'hA5A500, 0, 0};
        vecs[6] = '{4, 96'hA501FF00,     1'b1, 1, 24'hFF0000, 0, 0};
        vecs[7] = '{5, 96'hA5FFA50000,   1'b1, 0, 24'h000000, 0, 1};

        rst = 1'b1;
        frame_ack = 1'b0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_read", int'(uart_rx_read), 0);
        check("rst_valid", int'(frame_valid), 0);
        check("rst_len", int'(frame_len), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_errs", int'(err_chk) + int'(err_len) + int'(err_timeout), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            b_chk = n_chk;
            b_len = n_len;
            for (int k = 0; k < vecs[v].n; k++)
                stream.push_back(vecs[v].bytes[8*(vecs[v].n-1-k) +: 8]);
            quiesce(400);
            check($sformatf("v%0d_valid", v), int'(frame_valid), int'(vecs[v].valid));
            check($sformatf("v%0d_err_chk", v), n_chk - b_chk, vecs[v].e_chk);
            check($sformatf("v%0d_err_len", v), n_len - b_len, vecs[v].e_len);
            check($sformatf("v%0d_busy", v), int'(busy), 0);
            if (vecs[v].valid) begin
                check($sformatf("v%0d_len", v), int'(frame_len), vecs[v].len);
                for (int k = 0; k < vecs[v].len && k < 3; k++) begin
                    read_byte(k, d);
                    check($sformatf("v%0d_data%0d", v, k), int'(d),
                          int'(vecs[v].data[23-8*k -: 8]));
                end
                do_ack($sformatf("v%0d_ack", v));
            end
        end

        // Maximum-length payload
        stream.push_back(8'hA5);
        stream.push_back(8'd64);
        sum = 64;
        for (int k = 0; k < 64; k++) begin
            stream.push_back(8'(k * 3 + 1));
            sum += (k * 3 + 1) % 256;
        end
        stream.push_back(8'(sum));
        quiesce(400);
        check("max_valid", int'(frame_valid), 1);
        check("max_len", int'(frame_len), 64);
        read_byte(0, d);
        check("max_first", int'(d), 1);
        read_byte(63, d);
        check("max_last", int'(d), 190);
        do_ack("max_ack");

        // Inter-byte timeout
        b_to = n_to;
        stream.push_back(8'hA5);
        stream.push_back(8'h02);
        stream.push_back(8'h10);
        wait_drain(100);
        repeat (TO - 20) @(negedge clk);
        check("to_early", n_to - b_to, 0);
        check("to_busy_early", int'(busy), 1);
        repeat (40) @(negedge clk);
        check("to_pulse", n_to - b_to, 1);
        check("to_busy", int'(busy), 0);
        check("to_valid", int'(frame_valid), 0);

        // Back-to-back frames: second must wait in the FIFO until ack
        b_hp = n_holdpop;
        foreach (vecs[0].data[i]) ;
        stream.push_back(8'hA5); stream.push_back(8'h01);
        stream.push_back(8'h11); stream.push_back(8'h12);
        stream.push_back(8'hA5); stream.push_back(8'h02);
        stream.push_back(8'h21); stream.push_back(8'h22);
        stream.push_back(8'h45);
        wait_valid(200);
        repeat (40) @(negedge clk);
        check("bp_no_pop", n_holdpop - b_hp, 0);
        check("bp_fifo_left", stream.size() - rp, 5);
        check("bp_len1", int'(frame_len), 1);
        do_ack("bp_ack1");
        wait_valid(200);
        check("bp_len2", int'(frame_len), 2);
        read_byte(0, d);
        check("bp_d0", int'(d), 8'h21);
        read_byte(1, d);
        check("bp_d1", int'(d), 8'h22);
        do_ack("bp_ack2");

        // Reset mid-frame
        stream.push_back(8'hA5); stream.push_back(8'h05);
        stream.push_back(8'h01); stream.push_back(8'h02);
        wait_drain(100);
        check("mid_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(frame_valid), 0);
        check("mid_rst_len", int'(frame_len), 0);
        check("mid_rst_rd", int'(rd_data), 0);
        check("mid_rst_read", int'(uart_rx_read), 0);
        rst = 1'b0;
        stream.push_back(8'hA5); stream.push_back(8'h01);
        stream.push_back(8'h33); stream.push_back(8'h34);
        quiesce(400);
        check("post_rst_valid", int'(frame_valid), 1);
        read_byte(0, d);
        check("post_rst_d0", int'(d), 8'h33);
        do_ack("post_rst_ack");

        // Random stream against the reference parser
        for (int f = 0; f < 30; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--)
                s.push_back(8'($urandom_range(0, 255)));
            r = $urandom_range(0, 9);
            if (r <= 7) begin
                ln = (r == 0) ? 64 : $urandom_range(0, 64);
                s.push_back(8'hA5);
                s.push_back(8'(ln));
                sum = ln;
                for (int k = 0; k < ln; k++) begin
                    d = 8'($urandom_range(0, 255));
                    s.push_back(d);
                    sum += int'(d);
                end
                if (r >= 6) s.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
                else        s.push_back(8'(sum));
            end else if (r == 8) begin
                s.push_back(8'hA5);
                s.push_back(8'($urandom_range(65, 255)));
            end
        end
        model(s, ec, el, et);
        b_chk = n_chk;
        b_len = n_len;
        b_to  = n_to;
        foreach (s[i]) stream.push_back(s[i]);
        while (exp_len.size() > 0) begin
            ln = exp_len.pop_front();
            wait_valid(3000);
            check("rnd_len", int'(frame_len), ln);
            bad = 0;
            for (int k = 0; k < ln; k++) begin
                read_byte(k, d);
                if (d != exp_data.pop_front()) bad++;
            end
            check("rnd_data", bad, 0);
            do_ack("rnd_ack");
        end
        quiesce(3000);
        check("rnd_err_chk", n_chk - b_chk, ec);
        check("rnd_err_len", n_len - b_len, el);
        check("rnd_err_to", n_to - b_to, et);
        check("rnd_valid_end", int'(frame_valid), 0);

        check("err_exclusive", n_excl, 0);
        check("hold_pops", n_holdpop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
